// File: rtl/instruction_queue.sv
// Decoupling FIFO between instruction fetch and decode.
// Holds {instr, pc} entries in write order and presents the oldest one to decode
// through a valid/ready handshake. A flush empties the queue for a redirect.
module instruction_queue #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned ILEN       = 16,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                    clk_i,
    input  logic                    srst_i,
    input  logic                    flush_i,
    input  logic                    if_valid_i,
    input  logic [ILEN-1:0]         if_instr_i,
    input  logic [ADDR_WIDTH-1:0]   if_pc_i,
    output logic                    if_ready_o,
    output logic                    id_valid_o,
    output logic [ILEN-1:0]         id_instr_o,
    output logic [ADDR_WIDTH-1:0]   id_pc_o,
    input  logic                    id_ready_i,
    output logic [$clog2(DEPTH):0]  count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [ILEN-1:0]       instr;
        logic [ADDR_WIDTH-1:0] pc;
    } entry_t;

    entry_t             mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [CNT_W-1:0]   count_q;

    logic               full_c;
    logic               empty_c;
    logic               push_c;
    logic               pop_c;
    entry_t             head_c;

    // Status flags come from the occupancy register only, so ready/valid
    // never depend combinationally on the opposite side of the queue.
    always_comb begin
        full_c  = (count_q == CNT_W'(DEPTH));
        empty_c = (count_q == '0);
        push_c  = 1'b0;
        pop_c   = 1'b0;
        if (!flush_i) begin
            push_c = if_valid_i && !full_c;
            pop_c  = !empty_c && id_ready_i;
        end
    end

    // Entry storage; contents are never cleared, validity is tracked by count.
    always_ff @(posedge clk_i) begin
        if (!srst_i && push_c) begin
            mem_q[wr_ptr_q] <= entry_t'{instr: if_instr_i, pc: if_pc_i};
        end
    end

    // Write pointer: wraps naturally because DEPTH is a power of two.
    always_ff @(posedge clk_i) begin
        if (srst_i || flush_i) begin
            wr_ptr_q <= '0;
        end else if (push_c) begin
            wr_ptr_q <= wr_ptr_q + PTR_W'(1);
        end
    end

    // Read pointer: advances on every accepted pop.
    always_ff @(posedge clk_i) begin
        if (srst_i || flush_i) begin
            rd_ptr_q <= '0;
        end else if (pop_c) begin
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        end
    end

    // Occupancy: simultaneous push and pop leaves it unchanged.
    always_ff @(posedge clk_i) begin
        if (srst_i || flush_i) begin
            count_q <= '0;
        end else if (push_c && !pop_c) begin
            count_q <= count_q + CNT_W'(1);
        end else if (pop_c && !push_c) begin
            count_q <= count_q - CNT_W'(1);
        end
    end

    // Head entry, forced to zero whenever nothing is valid.
    always_comb begin
        head_c = '0;
        if (!empty_c) begin
            head_c = mem_q[rd_ptr_q];
        end
    end

    assign if_ready_o = !full_c;
    assign id_valid_o = !empty_c;
    assign id_instr_o = head_c.instr;
    assign id_pc_o    = head_c.pc;
    assign count_o    = count_q;

    // Occupancy must never exceed the physical depth.
    a_count_bound: assert property (@(posedge clk_i) disable iff (srst_i)
        count_q <= CNT_W'(DEPTH));

endmodule

// File: doc/instruction_queue.md
# instruction_queue

Decoupling FIFO between `instruction_fetch` and the decode stage. It captures each fetched instruction with its address and presents entries in order to decode through a valid/ready handshake. Decode can stall without losing fetched instructions. A flush (branch/jump redirect) discards everything buffered.

## Interface
- `ADDR_WIDTH`, default 32: instruction address width; matches `sp_pkg`.
- `ILEN`, default 16: instruction width; matches `sp_pkg`.
- `DEPTH`, default 4: number of entries; power of two, ≥ 2.
- `clk_i` in 1: the single clock; everything samples on its rising edge.
- `srst_i` in 1: reset, synchronous and active-high.
- `flush_i` in 1: discard all entries this cycle.
- `if_valid_i` in 1: fetch presents a valid instruction.
- `if_instr_i` in ILEN: instruction from fetch.
- `if_pc_i` in ADDR_WIDTH: address of `if_instr_i`.
- `if_ready_o` out 1: queue can accept an instruction.
- `id_valid_o` out 1: head entry valid for decode.
- `id_instr_o` out ILEN: head instruction.
- `id_pc_o` out ADDR_WIDTH: head address.
- `id_ready_i` in 1: decode consumes the head this cycle.
- `count_o` out $clog2(DEPTH)+1: number of occupied entries.

## Operation
- **Storage:**
  - DEPTH entries of {instr, pc}.
  - Write pointer and read pointer, each $clog2(DEPTH) bits, wrapping modulo DEPTH.
  - Occupancy counter, 0..DEPTH.
- **Push:** `if_valid_i && if_ready_o` writes the entry at the write pointer and increments the pointer.
- **Pop:** `id_valid_o && id_ready_i` increments the read pointer.
- **Counter update:**
  - Push only: +1.
  - Pop only: −1.
  - Both, or neither: unchanged.
- **`if_ready_o`:** `count != DEPTH`. Registered-state only; no combinational path from `id_ready_i`.
  - When full, a same-cycle pop does NOT enable a push.
- **`id_valid_o`:** `count != 0`. No empty bypass; input data never reaches the outputs combinationally.
- **Output data:**
  - `id_instr_o` / `id_pc_o` = head entry when `id_valid_o` = 1.
  - Both are driven to '0 when `id_valid_o` = 0.
- **`flush_i`:**
  - Next cycle: count = 0 and both pointers = 0.
  - Any push or pop in the flush cycle is ignored.
  - `if_ready_o` stays as computed from the pre-flush state.
- **Priority:** `srst_i` > `flush_i` > push/pop.
- **Data flow:** entries are never modified after a write and leave in write order. `if_pc_i` values are stored unaltered; no alignment check.
- **Reset values** (and reset mid-operation):
  - `count_o` = 0, `id_valid_o` = 0, `id_instr_o` = 0, `id_pc_o` = 0, `if_ready_o` = 1 after the reset edge.
  - Storage contents need not be cleared.
- **Illegal input:** `if_valid_i` while `if_ready_o` = 0 is legal; the instruction is not accepted and fetch must hold it.

## Timing
- **Latency:** a push at edge N makes the entry visible on `id_*` from edge N+1 when the queue was empty.
- **Throughput:** one push and one pop per cycle sustained when 0 < count < DEPTH.
- **Full:** with count = DEPTH, `if_ready_o` is 0. It returns to 1 the cycle after the first pop.
- **Empty:** with count = 0, `id_valid_o` is 0. It returns to 1 the cycle after the first push.
- **Pointer wrap:** write/read pointers step DEPTH−1 → 0 with no bubble.
- **Flush:**
  - `id_valid_o` = 0 in the cycle after `flush_i`.
  - The first post-flush push is visible one cycle later.
- **Registered outputs:** `id_valid_o`, `if_ready_o` and `count_o` depend only on registered state.
- **`srst_i` held:** outputs hold their reset values for every cycle it is asserted.

## Test plan
- **Reset:**
  - Stimulus: assert `srst_i` for 2 cycles while `if_valid_i` = 1.
  - Required: `count_o` = 0, `id_valid_o` = 0, `id_instr_o` = 0, `if_ready_o` = 1; nothing stored.
- **Fill and drain:**
  - Stimulus: `id_ready_i` = 0; push 0x1111@0x100, 0x2222@0x102, 0x3333@0x104, 0x4444@0x106; then hold `if_valid_i` = 1 with 0x5555@0x108 for 3 cycles.
  - Required: `count_o` = 4, `if_ready_o` = 0, 0x5555 not accepted.
  - Stimulus: raise `id_ready_i`.
  - Required: 0x1111..0x4444 appear in order with matching PCs.
- **Streaming and wrap:**
  - Stimulus: continuous push/pop of 10 instructions, PC 0x200 + 2k, `id_ready_i` = 1.
  - Required: output order matches input; `count_o` stays 1 after the first cycle; no bubbles across pointer wrap.
- **Full with simultaneous pop:**
  - Stimulus: count = 4; `id_ready_i` = 1 and `if_valid_i` = 1 in the same cycle.
  - Required: one pop only; `count_o` = 3 next cycle; the pushed word is accepted the following cycle.
- **Flush with traffic:**
  - Stimulus: count = 3; assert `flush_i` with `if_valid_i` = 1 (0xAAAA@0x300) and `id_ready_i` = 1.
  - Required: `count_o` = 0 and `id_valid_o` = 0 next cycle; 0xAAAA discarded.
  - Stimulus: push 0xBBBB@0x400.
  - Required: it is the next output.
- **Backpressure randomised:**
  - Stimulus: 1000 cycles of random `if_valid_i` / `id_ready_i` with occasional `flush_i`.
  - Required: the scoreboard matches order and data; `count_o` is always in 0..4.
